sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter_if.sv | 28 ++
 rtl/sdram_arbiter.sv | 131 +++++++++++++
 tb/tb_sdram_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// Request/command bundle between the SDRAM arbiter, its two requesters and the command engine.
interface sdram_arbiter_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              init_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ack;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              cmd_valid;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_done;
  logic              busy;
  logic              ref_overrun;

  modport slave (
    input  init_done, wr_req, wr_addr, rd_req, rd_addr, cmd_done,
    output wr_ack, rd_ack, cmd_valid, cmd_op, cmd_addr, busy, ref_overrun
  );

  modport master (
    output init_done, wr_req, wr_addr, rd_req, rd_addr, cmd_done,
    input  wr_ack, rd_ack, cmd_valid, cmd_op, cmd_addr, busy, ref_overrun
  );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM access arbiter: periodic auto-refresh first, then round-robin between
// the write (capture) and read (display) requesters, one command outstanding.
module sdram_arbiter #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned REF_PERIOD = 780
) (
  input  logic          S_CLK,
  input  logic          RST_N,
  sdram_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [1:0]  OP_WR  = 2'b01;
  localparam logic [1:0]  OP_RD  = 2'b10;
  localparam logic [1:0]  OP_REF = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_REFRESH, S_WRITE, S_READ} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  ref_cnt_q, ref_cnt_d;
  logic              ref_pend_q, ref_pend_d;
  logic              ref_overrun_q, ref_overrun_d;
  logic              last_rd_q, last_rd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [1:0]        cmd_op_q, cmd_op_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic              wr_ack_q, wr_ack_d;
  logic              rd_ack_q, rd_ack_d;
  logic              busy_q, busy_d;

  logic wrap, wr_elig, rd_elig, grant, ref_grant, release_c;

  // A requester still seeing its ack has not had a chance to drop req yet.
  assign wr_elig   = bus.wr_req && !wr_ack_q;
  assign rd_elig   = bus.rd_req && !rd_ack_q;
  assign wrap      = bus.init_done && (ref_cnt_q == CNT_W'(REF_PERIOD - 1));
  assign grant     = (state_q == S_IDLE) && (state_d != S_IDLE);
  assign ref_grant = (state_q == S_IDLE) && (state_d == S_REFRESH);
  assign release_c = (state_q != S_IDLE) && (state_d == S_IDLE);

  // State register
  always_ff @(posedge S_CLK) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: refresh beats requesters; ties go to whoever was not served last
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.init_done) begin
          if (ref_pend_q)                                state_d = S_REFRESH;
          else if (wr_elig && (!rd_elig || last_rd_q))   state_d = S_WRITE;
          else if (rd_elig)                              state_d = S_READ;
        end
      end
      default: if (bus.cmd_done) state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    cmd_valid_d = 1'b0;
    cmd_op_d    = cmd_op_q;
    cmd_addr_d  = cmd_addr_q;
    last_rd_d   = last_rd_q;
    wr_ack_d    = 1'b0;
    rd_ack_d    = 1'b0;
    busy_d      = (state_d != S_IDLE);
    if (grant) begin
      cmd_valid_d = 1'b1;
      case (state_d)
        S_WRITE: begin cmd_op_d = OP_WR; cmd_addr_d = bus.wr_addr; last_rd_d = 1'b0; end
        S_READ:  begin cmd_op_d = OP_RD; cmd_addr_d = bus.rd_addr; last_rd_d = 1'b1; end
        default: begin cmd_op_d = OP_REF; cmd_addr_d = '0; end
      endcase
    end
    if (release_c) begin
      wr_ack_d = (state_q == S_WRITE);
      rd_ack_d = (state_q == S_READ);
    end
  end

  // Refresh timer; a wrap on the refresh-grant edge re-arms the request instead of overrunning
  always_comb begin
    ref_cnt_d     = '0;
    ref_pend_d    = ref_pend_q;
    ref_overrun_d = ref_overrun_q;
    if (bus.init_done && !wrap) ref_cnt_d = ref_cnt_q + CNT_W'(1);
    if (wrap) begin
      ref_pend_d = 1'b1;
      if (ref_pend_q && !ref_grant) ref_overrun_d = 1'b1;
    end else if (ref_grant) begin
      ref_pend_d = 1'b0;
    end
  end

  always_ff @(posedge S_CLK) begin
    if (!RST_N) begin
      ref_cnt_q     <= '0;
      ref_pend_q    <= 1'b0;
      ref_overrun_q <= 1'b0;
      last_rd_q     <= 1'b1;
      cmd_valid_q   <= 1'b0;
      cmd_op_q      <= '0;
      cmd_addr_q    <= '0;
      wr_ack_q      <= 1'b0;
      rd_ack_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      ref_cnt_q     <= ref_cnt_d;
      ref_pend_q    <= ref_pend_d;
      ref_overrun_q <= ref_overrun_d;
      last_rd_q     <= last_rd_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_op_q      <= cmd_op_d;
      cmd_addr_q    <= cmd_addr_d;
      wr_ack_q      <= wr_ack_d;
      rd_ack_q      <= rd_ack_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.cmd_op      = cmd_op_q;
  assign bus.cmd_addr    = cmd_addr_q;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.rd_ack      = rd_ack_q;
  assign bus.busy        = busy_q;
  assign bus.ref_overrun = ref_overrun_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a short refresh period; cycle numbers
// in comments count edges after init_done is raised (C0 = cycle before edge 1).
module tb_sdram_arbiter;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned REF_P  = 16;

  logic S_CLK;
  logic RST_N;
  int   n_cmp = 0;
  int   n_bad = 0;

  sdram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  sdram_arbiter #(.ADDR_W(ADDR_W), .REF_PERIOD(REF_P)) dut (
    .S_CLK (S_CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial S_CLK = 1'b0;
  always #5 S_CLK = ~S_CLK;

  // {cmd_valid, cmd_op, cmd_addr, wr_ack, rd_ack, busy, ref_overrun}
  function automatic logic [26:0] full_obs();
    return {bus.cmd_valid, bus.cmd_op, bus.cmd_addr, bus.wr_ack, bus.rd_ack, bus.busy, bus.ref_overrun};
  endfunction

  // {cmd_valid, wr_ack, rd_ack, busy, ref_overrun}
  function automatic logic [4:0] ctl_obs();
    return {bus.cmd_valid, bus.wr_ack, bus.rd_ack, bus.busy, bus.ref_overrun};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge S_CLK);
    #1;
  endtask

  task automatic drive_idle();
    bus.init_done = 1'b0;
    bus.wr_req    = 1'b0;
    bus.rd_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.rd_addr   = '0;
    bus.cmd_done  = 1'b0;
  endtask

  task automatic do_reset();
    drive_idle();
    RST_N = 1'b0;
    tick(3);
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    logic [26:0] e;
    RST_N = 1'b0;
    bus.init_done = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.cmd_done = 1'b1;
    bus.wr_addr = 20'h11111; bus.rd_addr = 20'h22222;
    tick(3);
    e = '0;
    n_cmp++; if (full_obs() !== e) begin n_bad++; $display("FAIL reset_outputs: got %h want %h", full_obs(), e); end
    RST_N = 1'b1;
    drive_idle();
  endtask

  task automatic test_single_write();
    logic [26:0] e;
    logic [4:0]  c;
    do_reset();
    bus.init_done = 1'b1; bus.wr_req = 1'b1; bus.wr_addr = 20'h00001;  // C0
    tick();                                                            // C1
    e = {1'b1, 2'b01, 20'h00001, 4'b0010};
    n_cmp++; if (full_obs() !== e) begin n_bad++; $display("FAIL wr_grant: got %h want %h", full_obs(), e); end
    tick();                                                            // C2
    e = {1'b0, 2'b01, 20'h00001, 4'b0010};
    n_cmp++; if (full_obs() !== e) begin n_bad++; $display("FAIL wr_hold: got %h want %h", full_obs(), e); end
    tick(4);                                                           // C6
    bus.cmd_done = 1'b1;
    tick();                                                            // C7
    bus.cmd_done = 1'b0;
    c = 5'b01000;
    n_cmp++; if (ctl_obs() !== c) begin n_bad++; $display("FAIL wr_ack: got %b want %b", ctl_obs(), c); end
    tick();                                                            // C8: req was still high during ack
    c = 5'b00000;
    n_cmp++; if (ctl_obs() !== c) begin n_bad++; $display("FAIL wr_no_regrant: got %b want %b", ctl_obs(), c); end
    bus.wr_req = 1'b0;
    tick();                                                            // C9
    n_cmp++; if (ctl_obs() !== c) begin n_bad++; $display("FAIL wr_idle: got %b want %b", ctl_obs(), c); end
  endtask

  task automatic test_round_robin();
    logic [26:0] e;
    logic [4:0]  c;
    logic [1:0]  op;
    logic [19:0] ad;
    do_reset();
    bus.init_done = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    bus.wr_addr = 20'h00AAA; bus.rd_addr = 20'h00BBB;                  // C0
    for (int t = 0; t < 4; t++) begin
      tick();                                                          // grants at C1, C4, C7, C10
      op = (t % 2 == 0) ? 2'b01 : 2'b10;
      ad = (t % 2 == 0) ? 20'h00AAA : 20'h00BBB;
      e = {1'b1, op, ad, 4'b0010};
      n_cmp++; if (full_obs() !== e) begin n_bad++; $display("FAIL rr_grant%0d: got %h want %h", t, full_obs(), e); end
      if (t == 3) begin bus.wr_req = 1'b0; bus.rd_req = 1'b0; end
      tick();
      bus.cmd_done = 1'b1;
      tick();
      bus.cmd_done = 1'b0;
      c = {1'b0, (t % 2 == 0), (t % 2 == 1), 2'b00};
      n_cmp++; if (ctl_obs() !== c) begin n_bad++; $display("FAIL rr_ack%0d: got %b want %b", t, ctl_obs(), c); end
    end
    tick();                                                            // C13
    c = 5'b00000;
    n_cmp++; if (ctl_obs() !== c) begin n_bad++; $display("FAIL rr_done_idle: got %b want %b", ctl_obs(), c); end
  endtask

  task automatic test_tie_memory();
    logic [26:0] e;
    do_reset();
    bus.init_done = 1'b1; bus.wr_req = 1'b1; bus.wr_addr = 20'h00010;  // C0
    tick();                                                            // C1
    e = {1'b1, 2'b01, 20'h00010, 4'b0010};
    n_cmp++; if (full_obs() !== e) begin n_bad++; $display("FAIL tie_first_wr: got %h want %h", full_obs(), e); end
    bus.wr_req = 1'b0;
    tick(); bus.cmd_done = 1'b1;                                       // C2
    tick(); bus.cmd_done = 1'b0;                                       // C3 ack
    tick();                                                            // C4: clean tie
    bus.wr_req = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 20'h00020;
    tick();                                                            // C5
    e = {1'b1, 2'b10, 20'h00020, 4'b0010};
    n_cmp++; if (full_obs() !== e) begin n_bad++; $display("FAIL tie_after_write: got %h want %h", full_obs(), e); end
    bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    tick(); bus.cmd_done = 1'b1;
    tick(); bus.cmd_done = 1'b0;
  endtask

  task automatic test_refresh_priority();
    logic [26:0] e;
    logic [4:0]  c;
    logic        seen;
    do_reset();
    bus.init_done = 1'b1; bus.wr_addr = 20'h00042;                     // C0
    seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (bus.cmd_valid !== 1'b0) seen = 1'b1;
    end                                                                // C16: ref_pend just set
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL ref_early: got %b want 0", seen); end
    bus.wr_req = 1'b1;
    tick();                                                            // C17
    e = {1'b1, 2'b11, 20'h00000, 4'b0010};
    n_cmp++; if (full_obs() !== e) begin n_bad++; $display("FAIL ref_first: got %h want %h", full_obs(), e); end
    tick(); bus.cmd_done = 1'b1;                                       // C18
    tick(); bus.cmd_done = 1'b0;                                       // C19
    c = 5'b00000;
    n_cmp++; if (ctl_obs() !== c) begin n_bad++; $display("FAIL ref_no_ack: got %b want %b", ctl_obs(), c); end
    tick();                                                            // C20
    e = {1'b1, 2'b01, 20'h00042, 4'b0010};
    n_cmp++; if (full_obs() !== e) begin n_bad++; $display("FAIL wr_after_ref: got %h want %h", full_obs(), e); end
    bus.wr_req = 1'b0;
    tick(); bus.cmd_done = 1'b1;
    tick(); bus.cmd_done = 1'b0;                                       // C22
    c = 5'b01000;
    n_cmp++; if (ctl_obs() !== c) begin n_bad++; $display("FAIL ref_wr_ack: got %b want %b", ctl_obs(), c); end
  endtask

  task automatic test_overrun();
    logic [26:0] e;
    logic [4:0]  c;
    do_reset();
    bus.init_done = 1'b1; bus.wr_req = 1'b1; bus.wr_addr = 20'h00077;  // C0
    tick();                                                            // C1
    e = {1'b1, 2'b01, 20'h00077, 4'b0010};
    n_cmp++; if (full_obs() !== e) begin n_bad++; $display("FAIL ovr_wr_grant: got %h want %h", full_obs(), e); end
    bus.wr_req = 1'b0;
    tick(30);                                                          // C31
    c = 5'b00010;
    n_cmp++; if (ctl_obs() !== c) begin n_bad++; $display("FAIL ovr_before: got %b want %b", ctl_obs(), c); end
    tick();                                                            // C32: second wrap
    c = 5'b00011;
    n_cmp++; if (ctl_obs() !== c) begin n_bad++; $display("FAIL ovr_set: got %b want %b", ctl_obs(), c); end
    tick(8); bus.cmd_done = 1'b1;                                      // C40
    tick();  bus.cmd_done = 1'b0;                                      // C41
    c = 5'b01001;
    n_cmp++; if (ctl_obs() !== c) begin n_bad++; $display("FAIL ovr_wr_ack: got %b want %b", ctl_obs(), c); end
    tick();                                                            // C42
    e = {1'b1, 2'b11, 20'h00000, 4'b0011};
    n_cmp++; if (full_obs() !== e) begin n_bad++; $display("FAIL ovr_refresh: got %h want %h", full_obs(), e); end
    tick(); bus.cmd_done = 1'b1;
    tick(); bus.cmd_done = 1'b0;                                       // C44
    c = 5'b00001;
    n_cmp++; if (ctl_obs() !== c) begin n_bad++; $display("FAIL ovr_sticky: got %b want %b", ctl_obs(), c); end
  endtask

  task automatic test_refresh_wrap_edge();
    logic [26:0] e;
    do_reset();
    bus.init_done = 1'b1; bus.wr_req = 1'b1; bus.wr_addr = 20'h00099;  // C0
    tick(); bus.wr_req = 1'b0;                                         // C1
    tick(29); bus.cmd_done = 1'b1;                                     // C30
    tick();   bus.cmd_done = 1'b0;                                     // C31 ack
    tick();                                                            // C32: refresh grant on wrap edge
    e = {1'b1, 2'b11, 20'h00000, 4'b0010};
    n_cmp++; if (full_obs() !== e) begin n_bad++; $display("FAIL wrap_ref_grant: got %h want %h", full_obs(), e); end
    tick(); bus.cmd_done = 1'b1;                                       // C33
    tick(); bus.cmd_done = 1'b0;                                       // C34
    tick();                                                            // C35: pending survived the wrap
    n_cmp++; if (full_obs() !== e) begin n_bad++; $display("FAIL wrap_ref_again: got %h want %h", full_obs(), e); end
    tick(); bus.cmd_done = 1'b1;
    tick(); bus.cmd_done = 1'b0;
  endtask

  task automatic test_init_gating();
    logic [26:0] e;
    logic        seen;
    do_reset();
    bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (bus.cmd_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL gate_no_grant: got %b want 0", seen); end
    bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.init_done = 1'b1;        // C0
    seen = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (bus.cmd_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL gate_no_early_ref: got %b want 0", seen); end
    tick();                                                            // C17
    e = {1'b1, 2'b11, 20'h00000, 4'b0010};
    n_cmp++; if (full_obs() !== e) begin n_bad++; $display("FAIL gate_ref_phase: got %h want %h", full_obs(), e); end
    tick(); bus.cmd_done = 1'b1;
    tick(); bus.cmd_done = 1'b0;
  endtask

  task automatic test_reset_mid_cmd();
    logic [26:0] e;
    logic [4:0]  c;
    do_reset();
    bus.init_done = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 20'h12345;  // C0
    tick();                                                            // C1
    e = {1'b1, 2'b10, 20'h12345, 4'b0010};
    n_cmp++; if (full_obs() !== e) begin n_bad++; $display("FAIL rd_grant: got %h want %h", full_obs(), e); end
    bus.rd_req = 1'b0;
    tick(2);                                                           // C3
    RST_N = 1'b0;
    tick();                                                            // C4
    e = '0;
    n_cmp++; if (full_obs() !== e) begin n_bad++; $display("FAIL rst_mid_outputs: got %h want %h", full_obs(), e); end
    RST_N = 1'b1; bus.cmd_done = 1'b1;
    tick(); bus.cmd_done = 1'b0;                                       // C5
    c = 5'b00000;
    n_cmp++; if (ctl_obs() !== c) begin n_bad++; $display("FAIL rst_no_ack: got %b want %b", ctl_obs(), c); end
    tick();                                                            // C6
    n_cmp++; if (ctl_obs() !== c) begin n_bad++; $display("FAIL rst_idle: got %b want %b", ctl_obs(), c); end
  endtask

  initial begin
    RST_N = 1'b0;
    drive_idle();
    test_reset();
    test_single_write();
    test_round_robin();
    test_tie_memory();
    test_refresh_priority();
    test_overrun();
    test_refresh_wrap_edge();
    test_init_gating();
    test_reset_mid_cmd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
